// File: rtl/sa3_relu_pool.sv
// ReLU and 2x2 max-pool stage behind the 3x3 systolic array; streams four activations plus the pooled byte.
// Latency: done_sa3 -> first beat valid two edges later; holds every beat stable while out_ready is low.
module sa3_relu_pool #(
    parameter bit RELU_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done_sa3,
    input  logic [7:0] c11,
    input  logic [7:0] c12,
    input  logic [7:0] c21,
    input  logic [7:0] c22,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] pool_out,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] r   [4];
    logic [7:0] act [4];
    logic [7:0] rl  [4];
    logic [7:0] max01;
    logic [7:0] max23;
    logic [7:0] pool;
    logic [2:0] cnt;
    logic [2:0] cnt_inc;
    logic [7:0] next_byte;

    logic       capture;
    logic       calc;
    logic       advance;
    logic       finish;
    logic       hs;

    function automatic logic [7:0] relu(input logic [7:0] x);
        return (RELU_EN && x[7]) ? 8'h00 : x;
    endfunction

    function automatic logic [7:0] smax(input logic [7:0] a, input logic [7:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    assign hs      = out_valid && out_ready;
    assign busy    = (state != IDLE);
    assign cnt_inc = cnt + 3'd1;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rl[i] = relu(r[i]);
        end
        max01 = smax(rl[0], rl[1]);
        max23 = smax(rl[2], rl[3]);
        pool  = smax(max01, max23);
    end

    // Beat 4 is the pooled value, which already lives in pool_out.
    always_comb begin
        next_byte = pool_out;
        case (cnt_inc)
            3'd1:    next_byte = act[1];
            3'd2:    next_byte = act[2];
            3'd3:    next_byte = act[3];
            default: next_byte = pool_out;
        endcase
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        calc      = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (done_sa3) begin
                    capture   = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                calc      = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (hs) begin
                    advance = 1'b1;
                    if (cnt == 3'd4) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r[i]   <= 8'h00;
                act[i] <= 8'h00;
            end
            cnt       <= 3'd0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            pool_out  <= 8'h00;
        end else begin
            if (capture) begin
                r[0] <= c11;
                r[1] <= c12;
                r[2] <= c21;
                r[3] <= c22;
            end
            if (calc) begin
                for (int i = 0; i < 4; i++) begin
                    act[i] <= rl[i];
                end
                pool_out  <= pool;
                cnt       <= 3'd0;
                out_data  <= rl[0];
                out_valid <= 1'b1;
                out_last  <= 1'b0;
            end
            if (advance) begin
                if (finish) begin
                    cnt       <= 3'd0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    cnt      <= cnt_inc;
                    out_data <= next_byte;
                    out_last <= (cnt_inc == 3'd4);
                end
            end
        end
    end

    // A pulse on the final-handshake edge still sees SEND, so it counts as an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (done_sa3 && (state != IDLE)) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sa3_relu_pool.sv
// Runs a ReLU-enabled and a ReLU-bypassed instance side by side against a queue scoreboard.
module tb_sa3_relu_pool;

    logic       clk;
    logic       rst;
    logic       done_sa3;
    logic [7:0] c11, c12, c21, c22;
    logic       out_ready;

    logic [7:0] od   [2];
    logic       ov   [2];
    logic       ol   [2];
    logic [7:0] pl   [2];
    logic       by   [2];
    logic       orun [2];

    logic [8:0] q [2][$];
    int         total;
    int         bad;
    int         beats;
    bit         bp;
    bit         force_low;
    int         ph;

    sa3_relu_pool #(.RELU_EN(1'b1)) dut_on (
        .clk(clk), .rst(rst), .done_sa3(done_sa3),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .out_last(ol[1]), .pool_out(pl[1]), .busy(by[1]), .overrun(orun[1])
    );

    sa3_relu_pool #(.RELU_EN(1'b0)) dut_off (
        .clk(clk), .rst(rst), .done_sa3(done_sa3),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .out_last(ol[0]), .pool_out(pl[0]), .busy(by[0]), .overrun(orun[0])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_relu(input logic [7:0] x, input bit en);
        if (en && x[7]) return 8'h00;
        return x;
    endfunction

    task automatic push_win(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        logic [7:0] v [4];
        logic [7:0] pm;
        for (int e = 0; e < 2; e++) begin
            v[0] = m_relu(a, e == 1);
            v[1] = m_relu(b, e == 1);
            v[2] = m_relu(c, e == 1);
            v[3] = m_relu(d, e == 1);
            pm = v[0];
            for (int j = 1; j < 4; j++) begin
                if ($signed(v[j]) > $signed(pm)) pm = v[j];
            end
            for (int j = 0; j < 4; j++) q[e].push_back({1'b0, v[j]});
            q[e].push_back({1'b1, pm});
        end
    endtask

    task automatic send_done(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d, input bit expect_win);
        @(posedge clk);
        #1;
        c11 = a; c12 = b; c21 = c; c22 = d;
        done_sa3 = 1'b1;
        if (expect_win) push_win(a, b, c, d);
        @(posedge clk);
        #1;
        done_sa3 = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0 || by[0] || by[1]) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_drain"}, (n < 300), 1);
        @(negedge clk);
        chk({tag, "_valid_low"}, {ov[1], ov[0]}, 2'b00);
    endtask

    // Ready changes 2 time units after each edge so tasks driving at #1 win races.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (force_low) begin
                out_ready = 1'b0;
            end else if (bp) begin
                out_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (ov[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("extra_beat_%0d", i), q[i].size(), 1);
                    end else begin
                        chk($sformatf("data_%0d", i), od[i], q[i][0][7:0]);
                        chk($sformatf("last_%0d", i), ol[i], q[i][0][8]);
                        if (out_ready) begin
                            void'(q[i].pop_front());
                            if (i == 1) beats++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        total = 0; bad = 0; beats = 0;
        bp = 1'b0; force_low = 1'b0; ph = 0;
        rst = 1'b1; done_sa3 = 1'b0;
        c11 = 8'h00; c12 = 8'h00; c21 = 8'h00; c22 = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", od[1], 8'h00);
        chk("rst_valid", {ov[1], ov[0]}, 2'b00);
        chk("rst_last", {ol[1], ol[0]}, 2'b00);
        chk("rst_pool", pl[1], 8'h00);
        chk("rst_busy", {by[1], by[0]}, 2'b00);
        chk("rst_overrun", {orun[1], orun[0]}, 2'b00);
        rst = 1'b0;

        // Basic window with latency probe.
        send_done(8'd5, 8'hFD, 8'd12, 8'd7, 1'b1);
        @(negedge clk);
        chk("calc_busy", by[1], 1'b1);
        chk("calc_valid", ov[1], 1'b0);
        @(negedge clk);
        chk("first_valid", ov[1], 1'b1);
        chk("first_data", od[1], 8'd5);
        chk("basic_pool", pl[1], 8'd12);
        chk("basic_pool_off", pl[0], 8'd12);
        wait_idle("basic");
        chk("basic_pool_hold", pl[1], 8'd12);
        chk("basic_overrun", {orun[1], orun[0]}, 2'b00);

        send_done(8'hFF, 8'hFE, 8'h80, 8'hFB, 1'b1);
        wait_idle("neg");
        chk("neg_pool_on", pl[1], 8'h00);
        chk("neg_pool_off", pl[0], 8'hFF);

        // Backpressure with ready pattern 1,0,0 repeating.
        #1;
        ph = 0;
        bp = 1'b1;
        send_done(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        wait_idle("bp");
        bp = 1'b0;

        // Pulses seven cycles apart are both accepted.
        send_done(8'd10, 8'hF0, 8'd20, 8'd3, 1'b1);
        repeat (5) @(posedge clk);
        send_done(8'h81, 8'd2, 8'h7F, 8'd0, 1'b1);
        wait_idle("b2b7");
        chk("b2b7_overrun", {orun[1], orun[0]}, 2'b00);
        chk("b2b7_pool_off", pl[0], 8'h7F);

        // Second pulse mid-SEND is dropped and flagged.
        send_done(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        repeat (2) @(posedge clk);
        send_done(8'd9, 8'd9, 8'd9, 8'd9, 1'b0);
        wait_idle("ovr");
        chk("ovr_flag", {orun[1], orun[0]}, 2'b11);
        chk("ovr_pool", pl[1], 8'd4);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("ovr_sticky", {orun[1], orun[0]}, 2'b11);

        // Reset after the second beat has been accepted.
        base = beats;
        send_done(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        n = 0;
        while (beats < base + 2 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("rst_mid_reach", (n < 50), 1);
        #1;
        force_low = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        q[0].delete();
        q[1].delete();
        @(negedge clk);
        chk("rstmid_valid", {ov[1], ov[0]}, 2'b00);
        chk("rstmid_busy", {by[1], by[0]}, 2'b00);
        chk("rstmid_pool", pl[1], 8'h00);
        chk("rstmid_overrun", {orun[1], orun[0]}, 2'b00);
        rst = 1'b0;
        force_low = 1'b0;
        send_done(8'd8, 8'd0, 8'd0, 8'd0, 1'b1);
        wait_idle("post_rst");
        chk("post_rst_pool", pl[1], 8'd8);

        // Pulses six cycles apart: the second lands on the final handshake edge.
        send_done(8'd6, 8'd5, 8'd4, 8'd3, 1'b1);
        repeat (4) @(posedge clk);
        send_done(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        wait_idle("b2b6");
        chk("b2b6_overrun", {orun[1], orun[0]}, 2'b11);
        chk("b2b6_pool", pl[1], 8'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sa3_relu_pool.md
# sa3_relu_pool

Post-processing stage directly downstream of the 3x3 systolic array. It captures the four 8-bit convolution results (c11, c12, c21, c22) when the array pulses its done flag. It applies ReLU to each result and computes the 2x2 max-pool of the ReLU'd values. It then streams five bytes over a valid/ready interface to the next stage: four ReLU'd results followed by the pooled value.

## Interface
- RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass captured values unchanged (max-pool still computed, signed compare)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- done_sa3  input  1  single-cycle pulse from systolic array: c11..c22 valid this cycle
- c11, c12, c21, c22  input  8 each  array results, two's-complement signed
- out_data  output  8  stream byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts beat when out_valid && out_ready
- out_last  output  1  high with the 5th (pooled) beat only
- pool_out  output  8  registered pooled value of the current/last window
- busy  output  1  high in any state other than IDLE
- overrun  output  1  sticky: done_sa3 arrived while busy; cleared only by rst

## Operation
- Reset values: out_data=0, out_valid=0, out_last=0, pool_out=0, busy=0, overrun=0, state=IDLE, beat counter=0.
- States: IDLE, CALC, SEND.
- IDLE: on done_sa3=1, register c11,c12,c21,c22 into r0..r3 and go to CALC. Otherwise stay.
- CALC (one cycle):
  - ReLU each r_i: if RELU_EN and bit7=1, the value becomes 8'h00, else unchanged.
  - pool = signed max of the four ReLU'd values; on ties, any equal value.
  - Register all results; load pool_out; beat counter=0; go to SEND.
- SEND:
  - out_valid=1; out_data = relu(r0), relu(r1), relu(r2), relu(r3), pool for beats 0..4.
  - out_last=1 only on beat 4.
  - The counter advances only on a handshake (out_valid && out_ready).
  - On handshake of beat 4, go to IDLE.
  - While out_ready=0, out_data and out_last stay stable.
- done_sa3 while busy (CALC or SEND): ignored, captured data is not disturbed, overrun set to 1.
- done_sa3 on the same edge as the final-beat handshake: also counts as busy, so it is ignored and sets overrun.
- rst asserted mid-operation: on the next edge all state returns to reset values. Any partially sent window is discarded, with no further beats.
- Arithmetic: 8-bit only; no widening or saturation. The max uses a signed compare, so with RELU_EN=0 a negative max is possible.

## Timing
- done_sa3 sampled at edge k → CALC during cycle k+1 → out_valid high from edge k+2.
- With out_ready held at 1: beats at edges k+2..k+6. out_valid falls after edge k+6. IDLE again at k+6, so the earliest next accepted done_sa3 is at edge k+7.
- Minimum window period: 7 cycles. Each out_ready=0 cycle in SEND adds one cycle.
- busy high from edge k+1 through the final handshake edge.
- pool_out updates at edge k+2 and holds until the next window's CALC or rst.
- out_* are registered outputs, with no combinational path from out_ready to out_valid.

## Test plan
- Basic, RELU_EN=1, out_ready=1: c11=5, c12=-3 (8'hFD), c21=12, c22=7 → beats 5, 0, 12, 7, 12; out_last on beat 5 only; pool_out=12; done to first beat = 2 cycles.
- All negative: c=-1,-2,-128,-5 → beats 0,0,0,0,0; pool_out=0. With RELU_EN=0, the same inputs → beats FF, FE, 80, FB, FF.
- Backpressure: out_ready toggles 1,0,0,1,… on c=1,2,3,4 → order 1,2,3,4,4 preserved, data stable while stalled, no dropped or duplicated beats.
- Overrun: second done_sa3 with c=9,9,9,9 during SEND of the first window (1,2,3,4) → stream stays 1,2,3,4,4; overrun=1 and stays 1 until rst.
- Reset mid-SEND: rst after beat 2 accepted → next edge out_valid=0, busy=0, pool_out=0, overrun=0; a new done_sa3 with c=8,0,0,0 yields 8,0,0,0,8.
- Back-to-back: done_sa3 exactly 7 cycles apart with out_ready=1 → both windows complete, overrun stays 0. A pulse 6 cycles apart → overrun=1.
